// File: rtl/rv32m_pkg.sv
// Shared RV32M definitions: datapath width and the 2-bit divide op encoding
// used by both the control unit decoder and the divider.
package rv32m_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_e;

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic op_is_rem(input logic [1:0] op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/div_unit_cla.sv
// Parameterised adder (module cla) computing sum = a + b + cin with carry out;
// the divider drives it with an inverted divisor to form a subtraction.
module cla #(
  parameter int W = 33
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W-1:0] g;
  logic [W-1:0] p;
  logic [W:0]   c;

  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < W; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
  end

  assign sum  = p ^ c[W-1:0];
  assign cout = c[W];

endmodule

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU, with the
// divide-by-zero and signed-overflow cases answered directly from IDLE.
//
// state | meaning
// IDLE  | waiting for start; special cases resolved here in one cycle
// CALC  | one quotient bit per cycle, 32 iterations
// FIX   | sign correction and result load, done pulses next cycle
module div_unit #(
  parameter int XLEN = rv32m_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  import rv32m_pkg::*;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_e          state_q, state_d;
  div_op_e         op_q, op_d;
  logic            neg_quot_q, neg_quot_d;
  logic            neg_rem_q, neg_rem_d;
  logic [XLEN:0]   r_q, r_d;
  logic [XLEN-1:0] q_q, q_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [5:0]      cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [XLEN-1:0] result_q, result_d;

  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic [XLEN:0]   r_sh;
  logic [XLEN:0]   trial;
  logic            trial_ge;
  logic [XLEN-1:0] quot_fix, rem_fix;

  // Remainder stays below |B| between iterations, so the shifted value fits 33 bits.
  assign r_sh = (XLEN+1)'({r_q, q_q[XLEN-1]});

  cla #(.W(XLEN+1)) u_cla (
    .a    (r_sh),
    .b    (~{1'b0, b_q}),
    .cin  (1'b1),
    .sum  (trial),
    .cout (trial_ge)
  );

  always_comb begin
    a_neg    = op_is_signed(op) & A[XLEN-1];
    b_neg    = op_is_signed(op) & B[XLEN-1];
    a_mag    = a_neg ? -A : A;
    b_mag    = b_neg ? -B : B;
    quot_fix = neg_quot_q ? -q_q : q_q;
    rem_fix  = neg_rem_q ? -r_q[XLEN-1:0] : r_q[XLEN-1:0];

    state_d    = state_q;
    op_d       = op_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    r_d        = r_q;
    q_d        = q_q;
    b_d        = b_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    result_d   = result_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d = div_op_e'(op);
          if (B == '0) begin
            result_d = op_is_rem(op) ? A : '1;
            done_d   = 1'b1;
          end else if (op_is_signed(op) && (A == MIN_NEG) && (B == '1)) begin
            result_d = op_is_rem(op) ? '0 : MIN_NEG;
            done_d   = 1'b1;
          end else begin
            state_d    = S_CALC;
            busy_d     = 1'b1;
            r_d        = '0;
            q_d        = a_mag;
            b_d        = b_mag;
            cnt_d      = '0;
            neg_quot_d = (op == OP_DIV) && (a_neg ^ b_neg);
            neg_rem_d  = (op == OP_REM) && a_neg;
          end
        end
      end
      S_CALC: begin
        r_d   = trial_ge ? trial : r_sh;
        q_d   = {q_q[XLEN-2:0], trial_ge};
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'(XLEN-1)) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        result_d = op_is_rem(op_q) ? rem_fix : quot_fix;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        cnt_d    = '0;
        state_d  = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      op_q       <= OP_DIV;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      r_q        <= '0;
      q_q        <= '0;
      b_q        <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      r_q        <= r_d;
      q_q        <= q_d;
      b_q        <= b_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      result_q   <= result_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed RV32M cases, random operands
// against an arithmetic reference, start-while-busy, mid-op reset, back-to-back.
module tb_div_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int total = 0;
  int bad   = 0;

  div_unit #(.XLEN(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .A      (a),
    .B      (b),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    int sx;
    int sy;
    sx = x;
    sy = y;
    case (o)
      2'd0: begin
        if (y == 0) return 32'hFFFF_FFFF;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(sx / sy);
      end
      2'd1: begin
        if (y == 0) return 32'hFFFF_FFFF;
        return x / y;
      end
      2'd2: begin
        if (y == 0) return x;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h0;
        return 32'(sx % sy);
      end
      default: begin
        if (y == 0) return x;
        return x % y;
      end
    endcase
  endfunction

  function automatic int model_lat(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    if (y == 0) return 1;
    if (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    op    = o;
    a     = x;
    b     = y;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Called in cycle T+1; returns in the done cycle (lat = offset from T) or lat=-1 on timeout.
  task automatic wait_done(input int exp_lat, input int inject_k,
                           output logic [31:0] res, output int lat, output int busy_bad);
    lat      = -1;
    busy_bad = 0;
    res      = 'x;
    for (int k = 1; k <= 50; k++) begin
      if (done === 1'b1) begin
        lat = k;
        res = result;
        if (busy !== 1'b0) busy_bad++;
        break;
      end
      if (busy !== ((exp_lat == 1) ? 1'b0 : 1'b1)) busy_bad++;
      if (k == inject_k) begin
        start = 1'b1;
        op    = 2'($urandom_range(0, 3));
        a     = $urandom;
        b     = $urandom | 32'd1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    op    = 2'd0;
    a     = '0;
    b     = '0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
      bad++;
      $display("FAIL reset_vals: busy=%b done=%b result=%h want 0 0 0", busy, done, result);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
      bad++;
      $display("FAIL idle_after_reset: busy=%b done=%b result=%h want 0 0 0", busy, done, result);
    end
  endtask

  typedef struct {
    logic [1:0]  o;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  task automatic test_directed();
    vec_t        v[13];
    logic [31:0] res;
    int          lat;
    int          bb;
    v[0]  = '{2'd0, 32'd20,          32'hFFFF_FFFD, 32'hFFFF_FFFA, 34};
    v[1]  = '{2'd2, 32'hFFFF_FFEC,   32'd3,         32'hFFFF_FFFE, 34};
    v[2]  = '{2'd2, 32'd20,          32'hFFFF_FFFD, 32'd2,         34};
    v[3]  = '{2'd1, 32'hFFFF_FFFF,   32'd2,         32'h7FFF_FFFF, 34};
    v[4]  = '{2'd3, 32'hFFFF_FFFF,   32'd2,         32'd1,         34};
    v[5]  = '{2'd1, 32'd5,           32'd7,         32'd0,         34};
    v[6]  = '{2'd0, 32'd7,           32'd0,         32'hFFFF_FFFF, 1};
    v[7]  = '{2'd1, 32'd7,           32'd0,         32'hFFFF_FFFF, 1};
    v[8]  = '{2'd2, 32'd7,           32'd0,         32'd7,         1};
    v[9]  = '{2'd3, 32'd7,           32'd0,         32'd7,         1};
    v[10] = '{2'd0, 32'h8000_0000,   32'hFFFF_FFFF, 32'h8000_0000, 1};
    v[11] = '{2'd2, 32'h8000_0000,   32'hFFFF_FFFF, 32'd0,         1};
    v[12] = '{2'd1, 32'h8000_0000,   32'hFFFF_FFFF, 32'd0,         34};
    foreach (v[i]) begin
      launch(v[i].o, v[i].x, v[i].y);
      wait_done(v[i].lat, 0, res, lat, bb);
      total++;
      if (res !== v[i].exp) begin
        bad++;
        $display("FAIL dir%0d_result: got %h want %h", i, res, v[i].exp);
      end
      total++;
      if (lat != v[i].lat) begin
        bad++;
        $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, v[i].lat);
      end
      total++;
      if (bb != 0) begin
        bad++;
        $display("FAIL dir%0d_busy: %0d bad busy cycles want 0", i, bb);
      end
      @(posedge clk);
      #1;
      total++;
      if (done !== 1'b0 || result !== v[i].exp) begin
        bad++;
        $display("FAIL dir%0d_hold: done=%b result=%h want 0 %h", i, done, result, v[i].exp);
      end
    end
  endtask

  task automatic test_random();
    logic [1:0]  o;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] exp;
    logic [31:0] res;
    int          elat;
    int          lat;
    int          bb;
    for (int n = 0; n < 40; n++) begin
      o = 2'($urandom_range(0, 3));
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 7))
        0: y = 32'd0;
        1: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
        2: y = 32'($urandom_range(1, 15));
        3: x = 32'($urandom_range(0, 100));
        4: y = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        default: ;
      endcase
      exp  = model(o, x, y);
      elat = model_lat(o, x, y);
      launch(o, x, y);
      wait_done(elat, 0, res, lat, bb);
      total++;
      if (res !== exp) begin
        bad++;
        $display("FAIL rnd%0d_result op=%0d a=%h b=%h: got %h want %h", n, o, x, y, res, exp);
      end
      total++;
      if (lat != elat) begin
        bad++;
        $display("FAIL rnd%0d_latency: got %0d want %0d", n, lat, elat);
      end
      total++;
      if (bb != 0) begin
        bad++;
        $display("FAIL rnd%0d_busy: %0d bad busy cycles want 0", n, bb);
      end
    end
  endtask

  task automatic test_start_while_busy();
    logic [31:0] res;
    int          lat;
    int          bb;
    launch(2'd0, 32'hFFFF_F000, 32'd7);
    wait_done(34, 10, res, lat, bb);
    total++;
    if (res !== model(2'd0, 32'hFFFF_F000, 32'd7)) begin
      bad++;
      $display("FAIL busy_start_result: got %h want %h", res, model(2'd0, 32'hFFFF_F000, 32'd7));
    end
    total++;
    if (lat != 34) begin
      bad++;
      $display("FAIL busy_start_latency: got %0d want 34", lat);
    end
    @(posedge clk);
    #1;
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL busy_start_no_extra: done=%b busy=%b want 0 0", done, busy);
    end
  endtask

  task automatic test_reset_midop();
    logic [31:0] res;
    int          lat;
    int          bb;
    int          done_seen;
    launch(2'd1, 32'd123456, 32'd789);
    repeat (14) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
      bad++;
      $display("FAIL midop_reset: busy=%b done=%b result=%h want 0 0 0", busy, done, result);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n     = 1'b1;
    done_seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done === 1'b1 || busy === 1'b1) done_seen++;
    end
    total++;
    if (done_seen != 0) begin
      bad++;
      $display("FAIL midop_abandoned: %0d cycles with done/busy want 0", done_seen);
    end
    launch(2'd0, 32'd100, 32'd10);
    wait_done(34, 0, res, lat, bb);
    total++;
    if (res !== 32'd10 || lat != 34) begin
      bad++;
      $display("FAIL after_reset_div: got %h lat %0d want 0000000a lat 34", res, lat);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] res;
    int          lat;
    int          bb;
    launch(2'd1, 32'd1000, 32'd3);
    wait_done(34, 0, res, lat, bb);
    total++;
    if (res !== 32'd333 || lat != 34) begin
      bad++;
      $display("FAIL b2b_first: got %h lat %0d want 0000014d lat 34", res, lat);
    end
    launch(2'd2, 32'hFFFF_FF9C, 32'd7);
    wait_done(34, 0, res, lat, bb);
    total++;
    if (res !== 32'hFFFF_FFFE || lat != 34 || bb != 0) begin
      bad++;
      $display("FAIL b2b_second: got %h lat %0d busybad %0d want fffffffe lat 34 busybad 0", res, lat, bb);
    end
    launch(2'd3, 32'd55, 32'd0);
    wait_done(1, 0, res, lat, bb);
    total++;
    if (res !== 32'd55 || lat != 1 || bb != 0) begin
      bad++;
      $display("FAIL b2b_special: got %h lat %0d busybad %0d want 00000037 lat 1 busybad 0", res, lat, bb);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_start_while_busy();
    test_reset_midop();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
